// File: rtl/simon_serial_sequencer.sv
// simon_serial_sequencer
//   Phase and counter sequencer for the bit-serial SIMON 128/128 core.
//   Phases: IDLE -> LOAD (key/plaintext in) -> ENC (ROUNDS rounds) -> UNLOAD
//   (ciphertext out) -> IDLE, with a one-cycle done pulse on completion.
//   The state encoding is the data_rdy phase code, so data_rdy is the state register.
//   Optional feature macro: SIMON_SEQ_IRQ_EN adds a sticky irq output and an irq_clr input.
module simon_serial_sequencer #(
  parameter int CNT_W      = 6,
  parameter int ROUNDS     = 68,
  parameter int LOAD_WORDS = 2,
  parameter int OUT_WORDS  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
`ifdef SIMON_SEQ_IRQ_EN
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic [1:0]       data_rdy,
  output logic [CNT_W-1:0] bit_counter,
  output logic [6:0]       round_idx,
  output logic             word_idx,
  output logic             busy,
  output logic             in_ready,
  output logic             out_valid,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_UNLOAD = 2'b01,
    ST_LOAD   = 2'b10,
    ST_ENC    = 2'b11
  } state_t;

  localparam logic [6:0] LAST_ROUND     = 7'(ROUNDS - 1);
  localparam logic       LAST_LOAD_WORD = 1'(LOAD_WORDS - 1);
  localparam logic       LAST_OUT_WORD  = 1'(OUT_WORDS - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] bit_counter_reg;
  logic [6:0]       round_idx_reg;
  logic             word_idx_reg;
  logic             done_reg;

  logic bit_last;
  logic finish;

  // Last bit of a word, and the normal-completion condition of the final UNLOAD cycle
  assign bit_last = (bit_counter_reg == {CNT_W{1'b1}});
  assign finish   = (state_reg == ST_UNLOAD) && !abort && bit_last &&
                    (word_idx_reg == LAST_OUT_WORD);

  // Phase FSM with its bit/word/round counters; abort in any busy phase returns to IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      bit_counter_reg <= '0;
      round_idx_reg   <= '0;
      word_idx_reg    <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == ST_IDLE) begin
        bit_counter_reg <= '0;
        round_idx_reg   <= '0;
        word_idx_reg    <= 1'b0;
        if (start && !abort) begin
          state_reg <= ST_LOAD;
        end
      end else if (abort) begin
        state_reg       <= ST_IDLE;
        bit_counter_reg <= '0;
        round_idx_reg   <= '0;
        word_idx_reg    <= 1'b0;
      end else begin
        // bit_counter wraps naturally at the word boundary
        bit_counter_reg <= bit_counter_reg + 1'b1;
        if (bit_last) begin
          case (state_reg)
            ST_LOAD: begin
              if (word_idx_reg == LAST_LOAD_WORD) begin
                state_reg    <= ST_ENC;
                word_idx_reg <= 1'b0;
              end else begin
                word_idx_reg <= word_idx_reg + 1'b1;
              end
            end
            ST_ENC: begin
              if (round_idx_reg == LAST_ROUND) begin
                state_reg     <= ST_UNLOAD;
                round_idx_reg <= '0;
              end else begin
                round_idx_reg <= round_idx_reg + 7'd1;
              end
            end
            ST_UNLOAD: begin
              if (word_idx_reg == LAST_OUT_WORD) begin
                state_reg    <= ST_IDLE;
                word_idx_reg <= 1'b0;
                done_reg     <= 1'b1;
              end else begin
                word_idx_reg <= word_idx_reg + 1'b1;
              end
            end
            default: begin
              state_reg <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

`ifdef SIMON_SEQ_IRQ_EN
  logic irq_reg;

  // Sticky completion interrupt; a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= finish | (irq_reg & ~irq_clr);
    end
  end

  assign irq = irq_reg;
`else
  logic unused_finish;
  assign unused_finish = finish;
`endif

  assign data_rdy    = state_reg;
  assign bit_counter = bit_counter_reg;
  assign round_idx   = round_idx_reg;
  assign word_idx    = word_idx_reg;
  assign done        = done_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign in_ready    = (state_reg == ST_LOAD);
  assign out_valid   = (state_reg == ST_UNLOAD);

endmodule

// File: tb/tb_simon_serial_sequencer.sv
// tb_simon_serial_sequencer
//   Directed bench for simon_serial_sequencer with default parameters.
//   Define SIMON_SEQ_IRQ_EN to also exercise the irq feature.
module tb_simon_serial_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [1:0] data_rdy;
  logic [5:0] bit_counter;
  logic [6:0] round_idx;
  logic       word_idx;
  logic       busy;
  logic       in_ready;
  logic       out_valid;
  logic       done;
`ifdef SIMON_SEQ_IRQ_EN
  logic       irq;
  logic       irq_clr;
`endif

  int errors = 0;
  int checks = 0;

  simon_serial_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
`ifdef SIMON_SEQ_IRQ_EN
    .irq_clr    (irq_clr),
    .irq        (irq),
`endif
    .data_rdy   (data_rdy),
    .bit_counter(bit_counter),
    .round_idx  (round_idx),
    .word_idx   (word_idx),
    .busy       (busy),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle; returns at the negedge of the first LOAD cycle
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walk one operation from its first LOAD cycle to the first IDLE cycle, tallying
  // phase lengths and counting per-cycle deviations from the expected counters.
  task automatic run_op(input bit poke, output int lc, output int ec, output int uc,
                        output int errs, output bit timeout);
    int idx;
    lc = 0; ec = 0; uc = 0; errs = 0; timeout = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if (data_rdy == 2'd0) begin
        timeout = 1'b0;
        break;
      end
      if (poke) start = ((data_rdy == 2'd2 && lc == 5) || (data_rdy == 2'd3 && ec == 100));
      idx = (data_rdy == 2'd2) ? lc : (data_rdy == 2'd3) ? ec : uc;
      if (bit_counter !== 6'(idx % 64)) errs++;
      if (round_idx !== ((data_rdy == 2'd3) ? 7'(idx / 64) : 7'd0)) errs++;
      if (word_idx !== ((data_rdy == 2'd3) ? 1'b0 : 1'(idx / 64))) errs++;
      if (busy !== 1'b1 || done !== 1'b0) errs++;
      if (in_ready !== (data_rdy == 2'd2) || out_valid !== (data_rdy == 2'd1)) errs++;
      if (data_rdy == 2'd2 && (ec != 0 || uc != 0)) errs++;
      if (data_rdy == 2'd3 && uc != 0) errs++;
      if (data_rdy == 2'd2) lc++;
      else if (data_rdy == 2'd3) ec++;
      else uc++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
`ifdef SIMON_SEQ_IRQ_EN
    irq_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if ({data_rdy, bit_counter, round_idx, word_idx, busy, in_ready, out_valid, done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got dr=%0d bc=%0d r=%0d w=%0d busy=%0b done=%0b, want all 0",
               data_rdy, bit_counter, round_idx, word_idx, busy, done);
    end
`ifdef SIMON_SEQ_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b want 0", irq); end
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (data_rdy !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got dr=%0d busy=%0b done=%0b want 0 0 0", data_rdy, busy, done);
    end
    $display("test_reset done");
  endtask

  task automatic test_full_sequence();
    int lc, ec, uc, errs;
    bit to;
    start_pulse();
    run_op(1'b0, lc, ec, uc, errs, to);
    checks++;
    if (to) begin errors++; $display("FAIL full_timeout: operation never returned to IDLE"); end
    checks++;
    if (lc != 128 || ec != 4352 || uc != 128) begin
      errors++;
      $display("FAIL full_phase_len: got %0d/%0d/%0d want 128/4352/128", lc, ec, uc);
    end
    checks++;
    if (errs != 0) begin errors++; $display("FAIL full_counters: got %0d bad cycles want 0", errs); end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || data_rdy !== 2'd0) begin
      errors++;
      $display("FAIL full_done: got done=%0b busy=%0b dr=%0d want 1 0 0", done, busy, data_rdy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL full_done_width: got done=%0b want 0", done); end
    $display("test_full_sequence: load=%0d enc=%0d unload=%0d", lc, ec, uc);
  endtask

  task automatic test_abort();
    int lc, ec, uc, errs;
    bit to, found, bad;
    start_pulse();
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (data_rdy == 2'd3 && round_idx == 7'd10 && bit_counter == 6'd20) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL abort_reach: ENC round 10 bit 20 not reached"); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({data_rdy, bit_counter, round_idx, word_idx, busy, done} !== 17'd0) begin
      errors++;
      $display("FAIL abort_idle: got dr=%0d bc=%0d r=%0d w=%0d busy=%0b done=%0b want all 0",
               data_rdy, bit_counter, round_idx, word_idx, busy, done);
    end
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || data_rdy !== 2'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL abort_no_done: got done or busy after abort, want neither"); end
    start_pulse();
    run_op(1'b0, lc, ec, uc, errs, to);
    checks++;
    if (to || lc + ec + uc != 4608 || errs != 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL abort_rerun: got total=%0d errs=%0d done=%0b want 4608 0 1", lc + ec + uc, errs, done);
    end
    $display("test_abort: rerun total=%0d", lc + ec + uc);
  endtask

  task automatic test_start_ignored();
    int lc, ec, uc, errs;
    bit to;
    start_pulse();
    run_op(1'b1, lc, ec, uc, errs, to);
    checks++;
    if (to || lc != 128 || ec != 4352 || uc != 128 || errs != 0) begin
      errors++;
      $display("FAIL start_ignored: got %0d/%0d/%0d errs=%0d want 128/4352/128 0", lc, ec, uc, errs);
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL start_ignored_done: got %0b want 1", done); end
    @(negedge clk);
    checks++;
    if (data_rdy !== 2'd0) begin errors++; $display("FAIL start_ignored_queue: got dr=%0d want 0", data_rdy); end
    $display("test_start_ignored: total=%0d", lc + ec + uc);
  endtask

  task automatic test_async_reset();
    bit found, bad;
    start_pulse();
    found = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (data_rdy == 2'd1 && bit_counter == 6'd30) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL areset_reach: UNLOAD bit 30 not reached"); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({data_rdy, bit_counter, round_idx, word_idx, busy, in_ready, out_valid, done} !== 19'd0) begin
      errors++;
      $display("FAIL areset_immediate: got dr=%0d bc=%0d busy=%0b out_valid=%0b want all 0",
               data_rdy, bit_counter, busy, out_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || data_rdy !== 2'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL areset_no_done: got done or activity after reset, want none"); end
    $display("test_async_reset done");
  endtask

  task automatic test_back_to_back();
    int lc, ec, uc, errs;
    bit to;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    run_op(1'b0, lc, ec, uc, errs, to);
    start = 1'b1;
    checks++;
    if (to || lc + ec + uc != 4608 || done !== 1'b1 || data_rdy !== 2'd0) begin
      errors++;
      $display("FAIL b2b_first: got total=%0d done=%0b dr=%0d want 4608 1 0", lc + ec + uc, done, data_rdy);
    end
    @(negedge clk);
    checks++;
    if (data_rdy !== 2'd2 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: got dr=%0d done=%0b want 2 0", data_rdy, done);
    end
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (data_rdy !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_dominates: got dr=%0d busy=%0b want 0 0", data_rdy, busy);
    end
    $display("test_back_to_back done");
  endtask

`ifdef SIMON_SEQ_IRQ_EN
  task automatic test_irq();
    int lc, ec, uc, errs;
    bit to, found;
    @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear_initial: got %0b want 0", irq); end
    start_pulse();
    repeat (50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_abort: got %0b want 0", irq); end
    start_pulse();
    run_op(1'b0, lc, ec, uc, errs, to);
    checks++;
    if (to || done !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: got done=%0b irq=%0b want 1 1", done, irq);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %0b want 1", irq); end
    start_pulse();
    found = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (data_rdy == 2'd1 && word_idx == 1'b1 && bit_counter == 6'd63) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    checks++;
    if (!found || done !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set_wins: got found=%0b done=%0b irq=%0b want 1 1 1", found, done, irq);
    end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr_alone: got %0b want 0", irq); end
    $display("test_irq done");
  endtask
`endif

  initial begin
    test_reset();
    test_full_sequence();
    test_abort();
    test_start_ignored();
    test_back_to_back();
`ifdef SIMON_SEQ_IRQ_EN
    test_irq();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
